// File: rtl/inv_arb_pkg.sv
// ----------------------------------------------------------------------------
// inv_arb_pkg
//   Shared types and constants for the inverter arbiter slice.
//   - state_e    : arbiter FSM state encoding (IDLE/EXEC/RESP)
//   - NREQ_DEF   : default number of requesters
//   - WIDTH_DEF  : default operand/result width
//   - OP_COUNT_W : width of the completed-operation counter
// ----------------------------------------------------------------------------
package inv_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int unsigned NREQ_DEF   = 4;
   localparam int unsigned WIDTH_DEF  = 8;
   localparam int unsigned OP_COUNT_W = 16;

endpackage : inv_arb_pkg

// File: rtl/inv_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches upward from ptr, wrapping at
//   NREQ, and returns the first asserted request.
//   Ports:
//     req     in  NREQ   request vector
//     ptr     in  IDXW   search start index (0..NREQ-1)
//     grant   out NREQ   one-hot grant (all-zero when no request)
//     idx     out IDXW   index of the granted request
//     any_req out 1      at least one request asserted
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] idx,
   output logic            any_req
);

   always_comb begin
      int unsigned c;
      grant   = '0;
      idx     = '0;
      any_req = 1'b0;
      c       = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         // candidate index = (ptr + i) mod NREQ; first hit wins
         c = 32'(ptr) + i;
         if (c >= NREQ) c = c - NREQ;
         if (!any_req && req[c]) begin
            any_req = 1'b1;
            idx     = IDXW'(c);
         end
      end
      if (any_req) grant = NREQ'(1) << idx;
   end

endmodule : rr_pick

// File: rtl/inv_arbiter.sv
// ----------------------------------------------------------------------------
// inv_arbiter
//   Shares one external combinational inverter among NREQ requesters.
//   IDLE picks a requester round-robin and captures its operand, EXEC captures
//   the inverter result, RESP presents it until the granted requester accepts.
//   Optional feature macro: INV_ARB_LOCK_EN -- when defined, a requester that
//   holds req_lock high at its response handshake keeps the round-robin
//   pointer, so it wins the next arbitration if still valid.
//   Ports:
//     clk        in   clock (rising edge)
//     rst_n      in   asynchronous active-low reset
//     req_valid  in   NREQ        per-requester operand valid
//     req_data   in   NREQ*WIDTH  packed operands, slice i = [i*WIDTH +: WIDTH]
//     req_lock   in   NREQ        per-requester burst lock
//     req_ready  out  NREQ        one-hot operand accept strobe
//     resp_valid out  NREQ        one-hot result valid
//     resp_data  out  WIDTH       shared result bus
//     resp_ready in   NREQ        per-requester result accept
//     dp_a       out  WIDTH       operand to the external inverter
//     dp_y       in   WIDTH       inverter result
//     busy       out  1           FSM not in IDLE
//     op_count   out  16          saturating completed-operation counter
// ----------------------------------------------------------------------------
module inv_arbiter
   import inv_arb_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic [NREQ-1:0]         req_lock,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         resp_valid,
   output logic [WIDTH-1:0]        resp_data,
   input  logic [NREQ-1:0]         resp_ready,
   output logic [WIDTH-1:0]        dp_a,
   input  logic [WIDTH-1:0]        dp_y,
   output logic                    busy,
   output logic [OP_COUNT_W-1:0]   op_count
);

   localparam int unsigned IDXW = $clog2(NREQ);

   state_e                  state_q, state_d;
   logic [IDXW-1:0]         ptr_q, ptr_d;
   logic [IDXW-1:0]         g_q, g_d;
   logic [WIDTH-1:0]        op_q, op_d;
   logic [WIDTH-1:0]        res_q, res_d;
   logic [OP_COUNT_W-1:0]   cnt_q, cnt_d;

   logic [NREQ-1:0]         pick_grant;
   logic [IDXW-1:0]         pick_idx;
   logic                    pick_any;
   logic                    resp_hs;
   logic [IDXW-1:0]         ptr_next;

`ifndef INV_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^req_lock;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req     (req_valid),
      .ptr     (ptr_q),
      .grant   (pick_grant),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   assign resp_hs  = (state_q == ST_RESP) && resp_ready[g_q];
   assign ptr_next = (g_q == IDXW'(NREQ - 1)) ? '0 : g_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      g_d     = g_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               g_d     = pick_idx;
               op_d    = req_data[32'(pick_idx) * WIDTH +: WIDTH];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = dp_y;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_hs) begin
`ifdef INV_ARB_LOCK_EN
               ptr_d = req_lock[g_q] ? g_q : ptr_next;
`else
               ptr_d = ptr_next;
`endif
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   // rst_n gates the combinational strobe so nothing is accepted during reset
   assign req_ready  = (rst_n && state_q == ST_IDLE) ? pick_grant : '0;
   assign resp_valid = (state_q == ST_RESP) ? (NREQ'(1) << g_q) : '0;
   assign resp_data  = res_q;
   assign dp_a       = op_q;
   assign busy       = (state_q != ST_IDLE);
   assign op_count   = cnt_q;

endmodule : inv_arbiter

// File: tb/tb_inv_arbiter.sv
module tb_inv_arbiter;

   typedef struct {
      int unsigned idx;
      logic [7:0]  data;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  req_ready;
   logic [3:0]  resp_valid;
   logic [7:0]  resp_data;
   logic [3:0]  resp_ready;
   logic [7:0]  dp_a;
   logic [7:0]  dp_y;
   logic        busy;
   logic [15:0] op_count;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          hs_cnt = 0;
   logic        prev_rv = 1'b0;
   sb_t         exp_q[$];
   int unsigned grant_log[$];
   sb_t         mon_e;

   inv_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_lock   (req_lock),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .dp_a       (dp_a),
      .dp_y       (dp_y),
      .busy       (busy),
      .op_count   (op_count)
   );

   // external combinational inverter
   assign dp_y = ~dp_a;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard: push expected result at accept, pop at response handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_ready != 4'b0) begin
            check_eq("rdy_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < 4; i++) begin
               if (req_ready[i]) begin
                  mon_e.idx  = i;
                  mon_e.data = ~req_data[i*8 +: 8];
               end
            end
            exp_q.push_back(mon_e);
            grant_log.push_back(mon_e.idx);
            acc_cyc = cyc;
         end
         if (resp_valid != 4'b0 && !prev_rv) begin
            check_eq("latency", 32'(cyc - acc_cyc), 32'd2);
            check_eq("resp_expected", 32'(exp_q.size() != 0), 32'd1);
         end
         if ((resp_valid & resp_ready) != 4'b0 && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("resp_idx", 32'(resp_valid), 32'(4'b0001 << mon_e.idx));
            check_eq("resp_data", 32'(resp_data), 32'(mon_e.data));
            hs_cnt++;
         end
         prev_rv = (resp_valid != 4'b0);
      end else begin
         prev_rv = 1'b0;
      end
   end

   task automatic drain(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("drain_busy", 32'(busy), 32'd0);
      check_eq("drain_sb", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_q.delete();
      grant_log.delete();
      hs_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_op(input int i, input logic [7:0] d);
      int n = 0;
      req_data[i*8 +: 8] = d;
      req_valid = 4'b0001 << i;
      resp_ready = 4'b1111;
      while (req_ready == 4'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_eq("op_accept", 32'(req_ready), 32'(4'b0001 << i));
      @(posedge clk); #1;
      req_valid = 4'b0;
      drain(20);
   endtask

   task automatic run_grants(input int target);
      int n = 0;
      while (grant_log.size() < target && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      logic [7:0]  held_data;
      int unsigned exp_lock[4];
      int          n;

      rst_n = 1'b0; req_valid = 4'b1111; req_data = '0;
      req_lock = '0; resp_ready = '0;

      // reset state, even with requests pending
      #12;
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_data", 32'(resp_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_op_count", 32'(op_count), 32'd0);
      check_eq("rst_dp_a", 32'(dp_a), 32'd0);
      req_valid = '0;
      @(posedge clk); #1 rst_n = 1'b1;

      // single request
      req_data = 32'h0000_0001; req_valid = 4'b0001; resp_ready = 4'b1111;
      @(negedge clk);
      check_eq("single_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      check_eq("single_busy", 32'(busy), 32'd1);
      check_eq("single_dp_a", 32'(dp_a), 32'h01);
      drain(20);
      check_eq("single_cnt", 32'(op_count), 32'd1);

      // all four valid, round-robin from ptr 0
      apply_reset();
      req_data = {8'hFF, 8'hAA, 8'h55, 8'h00};
      req_valid = 4'b1111; resp_ready = 4'b1111;
      run_grants(5);
      req_valid = '0;
      check_eq("rr_count", 32'(grant_log.size()), 32'd5);
      for (int k = 0; k < 5 && k < grant_log.size(); k++)
         check_eq($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(k % 4));
      drain(20);
      check_eq("rr_op_count", 32'(op_count), 32'(hs_cnt));

      // backpressure: grant 1, other resp_ready bits high, others still valid
      req_data[15:8] = 8'h3C;
      req_valid = 4'b1010; resp_ready = 4'b0101;
      n = 0;
      while (resp_valid == 4'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_eq("bp_rv", 32'(resp_valid), 32'h2);
      held_data = resp_data;
      check_eq("bp_data", 32'(held_data), 32'hC3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq("bp_hold_rv", 32'(resp_valid), 32'h2);
         check_eq("bp_hold_data", 32'(resp_data), 32'(held_data));
         check_eq("bp_busy", 32'(busy), 32'd1);
         check_eq("bp_no_ready", 32'(req_ready), 32'd0);
         check_eq("bp_cnt", 32'(op_count), 32'd5);
      end
      @(posedge clk); #1;
      req_valid = '0; resp_ready = 4'b1111;
      drain(20);
      check_eq("bp_cnt_after", 32'(op_count), 32'd6);

      // reset during EXEC discards the operation
      req_data[7:0] = 8'h5A; req_valid = 4'b0001;
      @(negedge clk);
      check_eq("mid_accept", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      check_eq("mid_dp_a", 32'(dp_a), 32'h5A);
      rst_n = 1'b0;
      exp_q.delete();
      grant_log.delete();
      hs_cnt = 0;
      #1;
      check_eq("mid_busy", 32'(busy), 32'd0);
      check_eq("mid_dp_a0", 32'(dp_a), 32'd0);
      check_eq("mid_cnt", 32'(op_count), 32'd0);
      check_eq("mid_resp_data", 32'(resp_data), 32'd0);
      req_data[23:16] = 8'h0F; req_valid = 4'b0101;
      check_eq("mid_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_eq("mid_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      drain(20);

      // burst lock on requester 1 against requester 2
`ifdef INV_ARB_LOCK_EN
      exp_lock = '{1, 1, 1, 2};
`else
      exp_lock = '{1, 2, 1, 2};
`endif
      grant_log.delete();
      req_data[15:8] = 8'h11; req_data[23:16] = 8'h22;
      req_lock = 4'b0010; req_valid = 4'b0110; resp_ready = 4'b1111;
      run_grants(3);
      req_lock = '0;
      run_grants(4);
      req_valid = '0;
      check_eq("lock_count", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check_eq($sformatf("lock_grant%0d", k), 32'(grant_log[k]), 32'(exp_lock[k]));
      drain(20);

      // counter saturation
      @(posedge clk); #1;
      force dut.cnt_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut.cnt_q;
      @(posedge clk); #1;
      check_eq("sat_preload", 32'(op_count), 32'hFFFE);
      do_op(3, 8'h81);
      check_eq("sat_op1", 32'(op_count), 32'hFFFF);
      do_op(0, 8'h7E);
      check_eq("sat_op2", 32'(op_count), 32'hFFFF);
      do_op(2, 8'hC0);
      check_eq("sat_op3", 32'(op_count), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule : tb_inv_arbiter
